// File: rtl/conv_layer_scheduler.sv
// conv_layer_scheduler
//   Sequences a multi-layer convolution run on top of the conv control unit.
//   A small layer table holds, per layer, the channel-size select, the
//   image-size select and the number of output kernels. For each layer the
//   scheduler latches the selects, holds the CU in reset, then issues one
//   kernel-load request per output kernel, waiting for conv_DONE after each.
//
// Ports
//   clk, aresetn          : clock, asynchronous active-low reset
//   cfg_we/addr/wdata     : layer table write port {ch[13:12], img[11:9], oc[8:0]}
//   num_layers            : layers to run (sampled at start)
//   start, abort          : run request / run stop
//   conv_DONE             : pass-complete pulse from the CU
//   Kernel_BRAM_IDLE      : kernel BRAM loader idle
//   Reset_top             : active-low CU reset
//   Load_kernel_BRAM      : kernel-load request to the CU
//   CHANNEL_SIZE_choose,
//   IMAGE_SIZE_choose     : size selects to the CU, stable for a whole layer
//   busy, cur_layer,
//   cur_out_ch            : status / progress
//   layer_done, all_done  : one-cycle completion pulses
//   err                   : sticky error, cleared by an accepted start
module conv_layer_scheduler #(
  parameter int LAYER_AW = 3,
  parameter int RST_CYC  = 2
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                cfg_we,
  input  logic [LAYER_AW-1:0] cfg_addr,
  input  logic [13:0]         cfg_wdata,
  input  logic [LAYER_AW:0]   num_layers,
  input  logic                start,
  input  logic                abort,
  input  logic                conv_DONE,
  input  logic                Kernel_BRAM_IDLE,
  output logic                Reset_top,
  output logic                Load_kernel_BRAM,
  output logic [1:0]          CHANNEL_SIZE_choose,
  output logic [2:0]          IMAGE_SIZE_choose,
  output logic                busy,
  output logic [LAYER_AW-1:0] cur_layer,
  output logic [8:0]          cur_out_ch,
  output logic                layer_done,
  output logic                all_done,
  output logic                err
);

  localparam int DEPTH = 1 << LAYER_AW;
  localparam int RCW   = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [RCW-1:0]      RST_LAST = RCW'(RST_CYC - 1);
  localparam logic [LAYER_AW:0]   NL_MAX   = (LAYER_AW + 1)'(DEPTH);
  localparam logic [LAYER_AW:0]   NL_ONE   = (LAYER_AW + 1)'(1);
  localparam logic [LAYER_AW-1:0] L_ONE    = LAYER_AW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_CFG,
    S_RESET_CU,
    S_ISSUE,
    S_WAIT_DONE,
    S_NEXT_LAYER,
    S_ABORT
  } state_t;

  state_t                state_q, state_d;
  logic [RCW-1:0]        rst_cnt_q, rst_cnt_d;
  logic [LAYER_AW-1:0]   cur_layer_q, cur_layer_d;
  logic [8:0]            cur_out_ch_q, cur_out_ch_d;
  logic [LAYER_AW:0]     num_layers_q, num_layers_d;
  logic [8:0]            oc_q, oc_d;
  logic [1:0]            ch_q, ch_d;
  logic [2:0]            img_q, img_d;
  logic                  err_q, err_d;

  logic [13:0]           tbl [DEPTH];
  logic [13:0]           tbl_rd;
  logic                  last_kernel;
  logic                  last_layer;

  // Layer table: plain storage, contents are software-owned and not reset.
  // Writes are only accepted while idle, so a write in the start cycle lands
  // before S_LOAD_CFG reads the entry.
  always_ff @(posedge clk) begin
    if (cfg_we && (state_q == S_IDLE)) begin
      tbl[cfg_addr] <= cfg_wdata;
    end
  end

  assign tbl_rd      = tbl[cur_layer_q];
  assign last_kernel = (cur_out_ch_q == (oc_q - 9'd1));
  assign last_layer  = ({1'b0, cur_layer_q} == (num_layers_q - NL_ONE));

  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = '0;
    cur_layer_d  = cur_layer_q;
    cur_out_ch_d = cur_out_ch_q;
    num_layers_d = num_layers_q;
    oc_d         = oc_q;
    ch_d         = ch_q;
    img_d        = img_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((num_layers == '0) || (num_layers > NL_MAX)) begin
            err_d = 1'b1;
          end else begin
            err_d        = 1'b0;
            cur_layer_d  = '0;
            cur_out_ch_d = '0;
            num_layers_d = num_layers;
            state_d      = S_LOAD_CFG;
          end
        end
      end
      S_LOAD_CFG: begin
        if (tbl_rd[8:0] == 9'd0) begin
          err_d        = 1'b1;
          cur_layer_d  = '0;
          cur_out_ch_d = '0;
          state_d      = S_IDLE;
        end else begin
          // Selects only move here, right before the CU is held in reset.
          ch_d    = tbl_rd[13:12];
          img_d   = tbl_rd[11:9];
          oc_d    = tbl_rd[8:0];
          state_d = S_RESET_CU;
        end
      end
      S_RESET_CU: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_ISSUE;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_ISSUE: begin
        if (Kernel_BRAM_IDLE) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (conv_DONE) begin
          if (last_kernel) begin
            cur_out_ch_d = '0;
            state_d      = S_NEXT_LAYER;
          end else begin
            // CU self-resets after DONE; go straight to the next request.
            cur_out_ch_d = cur_out_ch_q + 9'd1;
            state_d      = S_ISSUE;
          end
        end
      end
      S_NEXT_LAYER: begin
        if (last_layer) begin
          state_d = S_IDLE;
        end else begin
          cur_layer_d = cur_layer_q + L_ONE;
          state_d     = S_LOAD_CFG;
        end
      end
      S_ABORT: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides whatever the state decided, including a DONE in the
    // same cycle, so no completion pulse can follow it.
    if (abort && (state_q != S_IDLE) && (state_q != S_ABORT)) begin
      state_d      = S_ABORT;
      rst_cnt_d    = '0;
      cur_layer_d  = '0;
      cur_out_ch_d = '0;
      err_d        = err_q;
      ch_d         = ch_q;
      img_d        = img_q;
      oc_d         = oc_q;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= '0;
      cur_layer_q  <= '0;
      cur_out_ch_q <= '0;
      num_layers_q <= '0;
      oc_q         <= '0;
      ch_q         <= '0;
      img_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      cur_layer_q  <= cur_layer_d;
      cur_out_ch_q <= cur_out_ch_d;
      num_layers_q <= num_layers_d;
      oc_q         <= oc_d;
      ch_q         <= ch_d;
      img_q        <= img_d;
      err_q        <= err_d;
    end
  end

  // Outputs decode registered state only; no input reaches them directly.
  assign Reset_top           = !((state_q == S_RESET_CU) || (state_q == S_ABORT));
  assign Load_kernel_BRAM    = (state_q == S_ISSUE);
  assign busy                = (state_q != S_IDLE);
  assign layer_done          = (state_q == S_NEXT_LAYER);
  assign all_done            = (state_q == S_NEXT_LAYER) && last_layer;
  assign CHANNEL_SIZE_choose = ch_q;
  assign IMAGE_SIZE_choose   = img_q;
  assign cur_layer           = cur_layer_q;
  assign cur_out_ch          = cur_out_ch_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
module tb_conv_layer_scheduler;
  localparam int LAW = 3;

  logic           clk = 1'b0;
  logic           aresetn = 1'b0;
  logic           cfg_we = 1'b0;
  logic [LAW-1:0] cfg_addr = '0;
  logic [13:0]    cfg_wdata = '0;
  logic [LAW:0]   num_layers = '0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic           conv_DONE = 1'b0;
  logic           Kernel_BRAM_IDLE = 1'b1;
  logic           Reset_top, Load_kernel_BRAM, busy, layer_done, all_done, err;
  logic [1:0]     CHANNEL_SIZE_choose;
  logic [2:0]     IMAGE_SIZE_choose;
  logic [LAW-1:0] cur_layer;
  logic [8:0]     cur_out_ch;

  always #5 clk = ~clk;

  conv_layer_scheduler #(.LAYER_AW(LAW), .RST_CYC(2)) dut (
    .clk(clk), .aresetn(aresetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .num_layers(num_layers), .start(start), .abort(abort),
    .conv_DONE(conv_DONE), .Kernel_BRAM_IDLE(Kernel_BRAM_IDLE),
    .Reset_top(Reset_top), .Load_kernel_BRAM(Load_kernel_BRAM),
    .CHANNEL_SIZE_choose(CHANNEL_SIZE_choose), .IMAGE_SIZE_choose(IMAGE_SIZE_choose),
    .busy(busy), .cur_layer(cur_layer), .cur_out_ch(cur_out_ch),
    .layer_done(layer_done), .all_done(all_done), .err(err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Bench copy of the layer table contents.
  logic [13:0] mtbl [8];

  // Event monitor: counts requests, pulses, CU reset windows, and select
  // changes seen while the CU is not in reset.
  int mon_req = 0, mon_load_cyc = 0, mon_ld = 0, mon_ad = 0;
  int mon_rst_starts = 0, mon_rst_cyc = 0, mon_sel_bad = 0;
  logic [4:0] mon_sel_q [$];
  logic       load_prev = 1'b0;
  logic       rt_prev = 1'b1;
  logic [4:0] sel_prev = '0;

  always @(negedge clk) begin
    if (aresetn) begin
      if (Load_kernel_BRAM && !load_prev) begin
        mon_req <= mon_req + 1;
        mon_sel_q.push_back({CHANNEL_SIZE_choose, IMAGE_SIZE_choose});
      end
      if (Load_kernel_BRAM) mon_load_cyc <= mon_load_cyc + 1;
      if (layer_done) mon_ld <= mon_ld + 1;
      if (all_done) mon_ad <= mon_ad + 1;
      if (!Reset_top && rt_prev) mon_rst_starts <= mon_rst_starts + 1;
      if (!Reset_top) mon_rst_cyc <= mon_rst_cyc + 1;
      if (({CHANNEL_SIZE_choose, IMAGE_SIZE_choose} != sel_prev) && Reset_top)
        mon_sel_bad <= mon_sel_bad + 1;
      load_prev <= Load_kernel_BRAM;
      rt_prev   <= Reset_top;
      sel_prev  <= {CHANNEL_SIZE_choose, IMAGE_SIZE_choose};
    end else begin
      load_prev <= 1'b0;
      rt_prev   <= 1'b1;
      sel_prev  <= '0;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(int a, logic [13:0] d);
    cfg_we = 1'b1; cfg_addr = a[LAW-1:0]; cfg_wdata = d; mtbl[a] = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(int nl);
    num_layers = nl[LAW:0]; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_load_hi(string tag);
    int n = 0;
    while (!Load_kernel_BRAM && n < 300) begin tick(); n++; end
    if (!Load_kernel_BRAM) check(tag, 32'(Load_kernel_BRAM), 1);
  endtask

  task automatic wait_load_lo(string tag);
    int n = 0;
    while (Load_kernel_BRAM && n < 300) begin tick(); n++; end
    if (Load_kernel_BRAM) check(tag, 32'(Load_kernel_BRAM), 0);
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while (busy && n < 500) begin tick(); n++; end
    if (busy) check(tag, 32'(busy), 0);
  endtask

  // CU stand-in: answer each request with a DONE after a random gap.
  task automatic serve(int n, int gmax);
    for (int i = 0; i < n; i++) begin
      wait_load_hi("serve_timeout_hi");
      wait_load_lo("serve_timeout_lo");
      tick($urandom_range(0, gmax));
      conv_DONE = 1'b1;
      tick();
      conv_DONE = 1'b0;
    end
  endtask

  // Full run against the table model: expected request count and the
  // select pair seen at each request follow directly from the table.
  task automatic run_model(string tag, int nl, int gmax);
    logic [4:0] eq [$];
    int tot = 0;
    int b_req = mon_req, b_ld = mon_ld, b_ad = mon_ad;
    int b_rs = mon_rst_starts, b_rc = mon_rst_cyc, b_sb = mon_sel_bad;
    int b_q = mon_sel_q.size();
    for (int l = 0; l < nl; l++) begin
      for (int k = 0; k < int'(mtbl[l][8:0]); k++) eq.push_back(mtbl[l][13:9]);
      tot += int'(mtbl[l][8:0]);
    end
    start_run(nl);
    serve(tot, gmax);
    wait_idle({tag, "_idle_timeout"});
    tick(2);
    check({tag, "_req_cnt"}, mon_req - b_req, tot);
    check({tag, "_layer_done"}, mon_ld - b_ld, nl);
    check({tag, "_all_done"}, mon_ad - b_ad, 1);
    check({tag, "_rst_windows"}, mon_rst_starts - b_rs, nl);
    check({tag, "_rst_cycles"}, mon_rst_cyc - b_rc, 2 * nl);
    check({tag, "_sel_outside_rst"}, mon_sel_bad - b_sb, 0);
    check({tag, "_err"}, 32'(err), 0);
    for (int i = 0; i < tot; i++) begin
      if (b_q + i < mon_sel_q.size())
        check({tag, "_req_sel"}, 32'(mon_sel_q[b_q + i]), 32'(eq[i]));
      else
        check({tag, "_req_missing"}, mon_sel_q.size(), b_q + tot);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_req, b_ld, b_ad, b_cyc, nl;

    // Reset values
    tick(2);
    check("rst_Reset_top", 32'(Reset_top), 1);
    check("rst_load", 32'(Load_kernel_BRAM), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sel", 32'({CHANNEL_SIZE_choose, IMAGE_SIZE_choose}), 0);
    check("rst_layer", 32'(cur_layer), 0);
    check("rst_och", 32'(cur_out_ch), 0);
    check("rst_done", 32'({layer_done, all_done}), 0);
    check("rst_err", 32'(err), 0);
    aresetn = 1'b1;
    tick(2);

    // Single layer, 2 kernels, cycle-exact timeline; the table write in the
    // start cycle must be the entry that is used.
    wr(0, {2'd3, 3'd7, 9'd5});
    b_req = mon_req; b_ld = mon_ld; b_ad = mon_ad;
    cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = {2'd1, 3'd0, 9'd2}; mtbl[0] = {2'd1, 3'd0, 9'd2};
    num_layers = 4'd1; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check("t1_c1_busy", 32'(busy), 1);
    check("t1_c1_rst", 32'(Reset_top), 1);
    check("t1_c1_load", 32'(Load_kernel_BRAM), 0);
    tick();
    check("t1_c2_rst", 32'(Reset_top), 0);
    check("t1_c2_ch", 32'(CHANNEL_SIZE_choose), 1);
    check("t1_c2_img", 32'(IMAGE_SIZE_choose), 0);
    tick();
    check("t1_c3_rst", 32'(Reset_top), 0);
    tick();
    check("t1_c4_rst", 32'(Reset_top), 1);
    check("t1_c4_load", 32'(Load_kernel_BRAM), 1);
    tick();
    check("t1_c5_load", 32'(Load_kernel_BRAM), 0);
    // write while busy must be ignored
    cfg_we = 1'b1; cfg_addr = '0; cfg_wdata = {2'd3, 3'd7, 9'd1};
    tick();
    cfg_we = 1'b0;
    tick(18);
    conv_DONE = 1'b1;
    tick();
    conv_DONE = 1'b0;
    check("t1_c25_load", 32'(Load_kernel_BRAM), 1);
    check("t1_c25_och", 32'(cur_out_ch), 1);
    tick(20);
    conv_DONE = 1'b1;
    tick();
    conv_DONE = 1'b0;
    check("t1_layer_done", 32'(layer_done), 1);
    check("t1_all_done", 32'(all_done), 1);
    check("t1_busy_at_done", 32'(busy), 1);
    check("t1_och_cleared", 32'(cur_out_ch), 0);
    tick();
    check("t1_busy_fall", 32'(busy), 0);
    check("t1_done_pulse", 32'({layer_done, all_done}), 0);
    tick();
    check("t1_req_cnt", mon_req - b_req, 2);
    check("t1_ld_cnt", mon_ld - b_ld, 1);
    check("t1_ad_cnt", mon_ad - b_ad, 1);
    check("t1_err", 32'(err), 0);
    run_model("t1b", 1, 3);

    // Three layers {3,1,2} with distinct selects
    wr(0, {2'd1, 3'd2, 9'd3});
    wr(1, {2'd2, 3'd5, 9'd1});
    wr(2, {2'd3, 3'd3, 9'd2});
    run_model("t2", 3, 4);

    // Randomized tables
    for (int it = 0; it < 6; it++) begin
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++)
        wr(l, {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 9'($urandom_range(1, 3))});
      run_model("rnd", nl, 3);
    end

    // Kernel BRAM busy for 10 cycles of S_ISSUE
    wr(0, {2'd2, 3'd1, 9'd1});
    Kernel_BRAM_IDLE = 1'b0;
    start_run(1);
    wait_load_hi("t3_timeout");
    b_cyc = mon_load_cyc;
    for (int i = 0; i < 10; i++) begin
      check("t3_load_held", 32'(Load_kernel_BRAM), 1);
      tick();
    end
    check("t3_load_11", 32'(Load_kernel_BRAM), 1);
    Kernel_BRAM_IDLE = 1'b1;
    tick();
    check("t3_load_drop", 32'(Load_kernel_BRAM), 0);
    check("t3_load_cycles", mon_load_cyc - b_cyc, 11);
    conv_DONE = 1'b1;
    tick();
    conv_DONE = 1'b0;
    wait_idle("t3_idle_timeout");

    // Abort together with the final DONE of the last layer
    wr(0, {2'd1, 3'd1, 9'd1});
    wr(1, {2'd2, 3'd2, 9'd2});
    b_ld = mon_ld; b_ad = mon_ad;
    start_run(2);
    serve(2, 2);
    wait_load_hi("t4_timeout_hi");
    wait_load_lo("t4_timeout_lo");
    tick(2);
    check("t4_pre_layer", 32'(cur_layer), 1);
    check("t4_pre_och", 32'(cur_out_ch), 1);
    conv_DONE = 1'b1; abort = 1'b1;
    tick();
    conv_DONE = 1'b0; abort = 1'b0;
    check("t4_a1_rst", 32'(Reset_top), 0);
    check("t4_a1_busy", 32'(busy), 1);
    check("t4_a1_done", 32'({layer_done, all_done}), 0);
    tick();
    check("t4_a2_rst", 32'(Reset_top), 0);
    tick();
    check("t4_end_busy", 32'(busy), 0);
    check("t4_end_rst", 32'(Reset_top), 1);
    check("t4_end_layer", 32'(cur_layer), 0);
    check("t4_end_och", 32'(cur_out_ch), 0);
    check("t4_end_err", 32'(err), 0);
    tick();
    check("t4_ld_cnt", mon_ld - b_ld, 1);
    check("t4_ad_cnt", mon_ad - b_ad, 0);

    // Error paths
    b_req = mon_req;
    start_run(0);
    check("t5_nl0_err", 32'(err), 1);
    check("t5_nl0_busy", 32'(busy), 0);
    tick();
    start_run(9);
    check("t5_nl9_err", 32'(err), 1);
    check("t5_nl9_busy", 32'(busy), 0);
    wr(0, {2'd1, 3'd2, 9'd0});
    start_run(1);
    check("t5_oc0_err_clr", 32'(err), 0);
    check("t5_oc0_busy", 32'(busy), 1);
    tick();
    check("t5_oc0_err", 32'(err), 1);
    check("t5_oc0_idle", 32'(busy), 0);
    check("t5_oc0_rst", 32'(Reset_top), 1);
    tick(3);
    check("t5_no_req", mon_req - b_req, 0);
    wr(0, {2'd1, 3'd2, 9'd1});
    run_model("t5_recover", 1, 2);

    // Asynchronous reset in S_WAIT_DONE
    wr(0, {2'd3, 3'd4, 9'd2});
    start_run(1);
    serve(1, 1);
    wait_load_hi("t6_timeout_hi");
    wait_load_lo("t6_timeout_lo");
    tick(2);
    check("t6_pre_och", 32'(cur_out_ch), 1);
    check("t6_pre_sel", 32'({CHANNEL_SIZE_choose, IMAGE_SIZE_choose}), 32'({2'd3, 3'd4}));
    #2 aresetn = 1'b0;
    #1;
    check("t6_Reset_top", 32'(Reset_top), 1);
    check("t6_load", 32'(Load_kernel_BRAM), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_sel", 32'({CHANNEL_SIZE_choose, IMAGE_SIZE_choose}), 0);
    check("t6_idx", 32'({cur_layer, cur_out_ch}), 0);
    check("t6_done", 32'({layer_done, all_done}), 0);
    check("t6_err", 32'(err), 0);
    tick();
    aresetn = 1'b1;
    tick(2);
    check("t6_after_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/conv_layer_scheduler.md
# conv_layer_scheduler

Sequences a multi-layer convolution run on top of the conv control unit. Holds a small programmable layer table: per layer, channel-size select, image-size select and output-kernel count. For each layer it configures the CU size selects, resets the CU, then issues one `Load_kernel_BRAM` request per output kernel, waiting for `conv_DONE` between them. It sits between the GPIO/PS register bank and the conv CU, replacing direct software sequencing of `Reset_top` and `Load_kernel_BRAM`.

## Interface
Parameters:
- `LAYER_AW`, 3: layer table address width; depth = 2^LAYER_AW (8).
- `RST_CYC`, 2: cycles `Reset_top` is held low per CU reset.

Ports (clock and reset first):
- `clk` in 1: single clock, all logic rising-edge.
- `aresetn` in 1: reset is asynchronous and active-low.
- `cfg_we` in 1: table write strobe; ignored while `busy`.
- `cfg_addr` in LAYER_AW: table entry index.
- `cfg_wdata` in 14: [13:12] CHANNEL_SIZE_choose, [11:9] IMAGE_SIZE_choose, [8:0] out_ch_count (1..256; 0 = invalid; value 256 encoded as 9'd256).
- `num_layers` in LAYER_AW+1: layers to run, 1..2^LAYER_AW.
- `start` in 1: run request; sampled only in S_IDLE.
- `abort` in 1: stop run.
- `conv_DONE` in 1: one-cycle pass-complete pulse from CU.
- `Kernel_BRAM_IDLE` in 1: kernel BRAM loader idle.
- `Reset_top` out 1: active-low CU reset.
- `Load_kernel_BRAM` out 1: kernel-load request to CU.
- `CHANNEL_SIZE_choose` out 2, `IMAGE_SIZE_choose` out 3: registered size selects to CU.
- `busy` out 1: high in every state except S_IDLE.
- `cur_layer` out LAYER_AW, `cur_out_ch` out 9: progress indices.
- `layer_done` out 1: one-cycle pulse after the last kernel of a layer.
- `all_done` out 1: one-cycle pulse at run completion.
- `err` out 1: sticky; cleared by an accepted `start`.

## Operation
- Reset values: state S_IDLE, `Reset_top`=1, `Load_kernel_BRAM`=0, selects=0, `busy`=0, `cur_layer`=0, `cur_out_ch`=0, `layer_done`=0, `all_done`=0, `err`=0. Table contents are undefined after reset; software must write them.
- States:
  - **S_IDLE**: `start` is accepted. If `num_layers`=0 or `num_layers` > 2^LAYER_AW, set `err` and stay in S_IDLE. Otherwise clear `err` and counters, then go to S_LOAD_CFG.
  - **S_LOAD_CFG**: read `table[cur_layer]` and register the selects and out_ch_count. If out_ch_count=0, set `err` and go to S_IDLE. Otherwise go to S_RESET_CU.
  - **S_RESET_CU**: `Reset_top`=0 for RST_CYC cycles, then go to S_ISSUE.
  - **S_ISSUE**: `Load_kernel_BRAM`=1. On the first cycle with `Kernel_BRAM_IDLE`=1, go to S_WAIT_DONE; `Load_kernel_BRAM` drops the following cycle.
  - **S_WAIT_DONE**: wait for `conv_DONE`.
    - If `cur_out_ch` = out_ch_count−1: pulse `layer_done`, clear `cur_out_ch`, go to S_NEXT_LAYER.
    - Otherwise: increment `cur_out_ch`, go to S_ISSUE. The CU self-resets after DONE, so no `Reset_top` is issued here.
  - **S_NEXT_LAYER**:
    - If `cur_layer` = `num_layers`−1: pulse `all_done`, go to S_IDLE.
    - Otherwise: increment `cur_layer`, go to S_LOAD_CFG.
  - **S_ABORT**: `Reset_top`=0 for RST_CYC cycles, then go to S_IDLE. Counters are cleared and `err` is not set.
- `abort` in any busy state (except S_ABORT) goes to S_ABORT next cycle. Abort wins over a simultaneous `conv_DONE`; no done pulses are issued.
- The size selects change only in S_LOAD_CFG, i.e. only while the CU is about to be held in reset. They are stable for the whole layer.
- `num_layers` is sampled at `start` and held internally. `start` while busy is ignored.
- A `cfg_we` write in the same cycle as an accepted `start` is committed before S_LOAD_CFG reads the table.
- `conv_DONE` outside S_WAIT_DONE is ignored.

## Timing
- `start` at cycle 0:
  - S_LOAD_CFG at cycle 1.
  - `Reset_top` low at cycles 2..1+RST_CYC.
  - `Load_kernel_BRAM` high from cycle 2+RST_CYC.
- Kernel request latency: with `Kernel_BRAM_IDLE` already high, `Load_kernel_BRAM` is high for exactly 1 cycle.
- `conv_DONE` to next `Load_kernel_BRAM` (same layer): 1 cycle.
- Layer boundary, `conv_DONE` to next layer's `Reset_top` low: 3 cycles (NEXT_LAYER, LOAD_CFG, then RESET_CU).
- `all_done` is asserted 1 cycle after the final `conv_DONE`; `busy` falls the cycle after that.
- All outputs are registered or decoded from registered state; there is no combinational path from inputs to `Load_kernel_BRAM` or `Reset_top`.

## Test plan
- Write layer0 = {2'd1, 3'd0, 9'd2}, `num_layers`=1, pulse `start`, answer each `Load_kernel_BRAM` with `conv_DONE` 20 cycles later -> exactly 2 requests, selects 1/0, one `layer_done`, one `all_done`, `err`=0.
- Three layers with out_ch_count {3,1,2} and distinct selects -> 6 requests total. Selects change only while `Reset_top`=0, and `Reset_top` low for 2 cycles at each of 3 layer starts.
- Hold `Kernel_BRAM_IDLE`=0 for 10 cycles in S_ISSUE -> `Load_kernel_BRAM` stays high for 11 cycles, and the state advances only on the idle cycle.
- `abort` in the same cycle as `conv_DONE` mid-layer -> S_ABORT, `Reset_top` low 2 cycles, no `layer_done`/`all_done`, then `busy`=0 and `cur_layer`=0.
- `num_layers`=0, then a table entry with out_ch_count=0 -> `err` set, no `Load_kernel_BRAM`. The next valid `start` clears `err`.
- `aresetn` asserted mid-run while in S_WAIT_DONE -> all outputs take reset values immediately, asynchronously and without a clock edge.
